// File: rtl/elastic_buffer.sv
// DEPTH-entry registered valid/ready elastic queue: a head register feeding fwd_data_o
// plus a (DEPTH-1)-entry ring. Optional flush_i port enabled by macro ELASTIC_BUF_FLUSH_EN.
module elastic_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef ELASTIC_BUF_FLUSH_EN
   input  logic                  flush_i,
`endif
   input  logic [DATA_WIDTH-1:0] bwd_data_i,
   input  logic                  bwd_valid_i,
   output logic                  bwd_ready_o,
   output logic [DATA_WIDTH-1:0] fwd_data_o,
   output logic                  fwd_valid_o,
   input  logic                  fwd_ready_i,
   output logic [CNT_W-1:0]      count_o
);

   localparam int RING_N = DEPTH - 1;
   localparam int PTR_W  = (DEPTH > 2) ? $clog2(RING_N) : 1;

   logic [DATA_WIDTH-1:0] ring_q [RING_N];
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic                  valid_q, valid_d;
   logic                  ready_q, ready_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic                  push_s, pop_s, take_s, ring_ne_s, ring_we_s, flush_s;

`ifdef ELASTIC_BUF_FLUSH_EN
   assign flush_s = flush_i;
`else
   assign flush_s = 1'b0;
`endif

   // Ring pointers wrap by compare so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RING_N - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   // Next-state: head refill/bypass, ring write, occupancy and registered handshakes.
   always_comb begin
      push_s    = bwd_valid_i & ready_q;
      pop_s     = valid_q & fwd_ready_i;
      take_s    = ~valid_q | fwd_ready_i;
      ring_ne_s = (count_q > CNT_W'(1));
      head_d    = head_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      ring_we_s = 1'b0;

      if (take_s) begin
         if (ring_ne_s) begin
            head_d   = ring_q[rd_ptr_q];
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end else if (push_s) begin
            head_d = bwd_data_i;
         end else begin
            head_d = head_q;
         end
      end else begin
         head_d = head_q;
      end

      // The head is always occupied when count is non-zero, so only an empty ring bypasses.
      if (push_s && !(take_s && !ring_ne_s)) begin
         ring_we_s = 1'b1;
         wr_ptr_d  = ptr_inc(wr_ptr_q);
      end else begin
         ring_we_s = 1'b0;
      end

      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

      if (flush_s) begin
         count_d   = {CNT_W{1'b0}};
         rd_ptr_d  = {PTR_W{1'b0}};
         wr_ptr_d  = {PTR_W{1'b0}};
         ring_we_s = 1'b0;
      end else begin
         count_d = count_d;
      end

      valid_d = (count_d != {CNT_W{1'b0}});
      ready_d = (count_d < CNT_W'(DEPTH));
   end

   // Control and head registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q   <= {DATA_WIDTH{1'b0}};
         valid_q  <= 1'b0;
         ready_q  <= 1'b0;
         count_q  <= {CNT_W{1'b0}};
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
      end else begin
         head_q   <= head_d;
         valid_q  <= valid_d;
         ready_q  <= ready_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Ring storage needs no reset; occupancy tracking guards every read.
   always_ff @(posedge clk) begin
      if (ring_we_s) begin
         ring_q[wr_ptr_q] <= bwd_data_i;
      end
   end

   assign fwd_data_o  = head_q;
   assign fwd_valid_o = valid_q;
   assign bwd_ready_o = ready_q;
   assign count_o     = count_q;

endmodule

// File: doc/elastic_buffer.md
# elastic_buffer

Parametrised elastic buffer that generalises the single-slot valid/ready skid stage into a DEPTH-entry, fully registered, in-order queue. It holds DEPTH beats and runs at one beat per cycle in steady state. Every output is driven straight from a flop, so long valid/ready paths can be cut inside the AXI data-width adapter. It sits between any two valid/ready stages, for example on the upsizer/downsizer beat paths. An occupancy output and an optional synchronous flush are provided.

## Interface
- DATA_WIDTH, 8: payload width in bits.
- DEPTH, 4: total capacity in beats, minimum 2, need not be a power of two.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count (derived; do not override).
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  reset: synchronous, active-high.
- bwd_data_i  input  DATA_WIDTH  upstream payload.
- bwd_valid_i  input  1  upstream valid.
- bwd_ready_o  output  1  ready to upstream (registered).
- fwd_data_o  output  DATA_WIDTH  downstream payload (registered).
- fwd_valid_o  output  1  downstream valid (registered).
- fwd_ready_i  input  1  downstream ready.
- count_o  output  CNT_W  current occupancy, 0..DEPTH (registered).
- flush_i  input  1  synchronous discard of all contents; present only with ELASTIC_BUF_FLUSH_EN.

## Operation
- Handshakes: push = bwd_valid_i & bwd_ready_o; pop = fwd_valid_o & fwd_ready_i.
- Storage: one head register drives fwd_data_o, plus a ring of DEPTH-1 entries.
  - The ring has a write pointer and a read pointer.
  - Each pointer wraps from DEPTH-2 to 0 by compare, so any DEPTH ≥ 2 works.
- Head update, in priority order:
  - Head empty or popped, ring non-empty: head loads the ring entry at the read pointer; the read pointer advances.
  - Head empty or popped, ring empty, push: head loads bwd_data_i directly (bypass).
  - Head empty or popped, nothing to load: head goes invalid.
- Push without bypass writes the ring at the write pointer; the write pointer advances.
- Order: strict FIFO. No beat is dropped or duplicated, except on flush.
- count_next = count + push - pop.
- bwd_ready_o is registered as (count_next < DEPTH).
- fwd_valid_o is registered as (count_next != 0).
- Stability: while fwd_valid_o & !fwd_ready_i, fwd_data_o and fwd_valid_o are held unchanged.
- Non-head ring contents need no reset; the head data register resets to 0.

## Timing
- Reset, while rst is high: fwd_valid_o=0, fwd_data_o=0, count_o=0, bwd_ready_o=0.
- First cycle after rst deasserts: bwd_ready_o=1.
- Reset mid-operation: all contents are discarded at the next edge, and the reset values above apply.
- Latency: a beat pushed at edge T into an empty buffer shows fwd_valid_o=1 with its data in cycle T+1.
- Throughput: with fwd_ready_i held high, one beat per cycle is sustained indefinitely with no bubbles.
- Full (count=DEPTH):
  - bwd_ready_o=0.
  - A pop at edge T makes bwd_ready_o=1 in cycle T+1. A single upstream bubble after full is acceptable.
- Simultaneous push and pop:
  - count is unchanged.
  - When count=1, the incoming beat goes straight to the head via bypass.
- Empty: fwd_valid_o=0; fwd_ready_i is ignored.

## Configuration
- Macro ELASTIC_BUF_FLUSH_EN: adds the flush_i port.
- With the macro, flush_i=1 at edge T:
  - After T: count_o=0, fwd_valid_o=0, both ring pointers at 0, bwd_ready_o=1.
  - A push in the same cycle is accepted and discarded; flush has priority over push and pop.
  - The head data value is don't-care.
- Without the macro: the port is absent, and behaviour is identical to flush_i tied to 0.

## Test plan
- Reset release, DEPTH=4, DATA_WIDTH=8:
  - While rst=1: all outputs 0.
  - One cycle after release: bwd_ready_o=1, count_o=0.
- Fill, then drain, DEPTH=4:
  - Push 0x11, 0x22, 0x33, 0x44 with fwd_ready_i=0 → count_o=4, bwd_ready_o=0, fwd_data_o=0x11 held.
  - Then fwd_ready_i=1 → 0x11..0x44 emerge in order on consecutive cycles; count_o reaches 0; fwd_valid_o=0 after the last beat.
- Streaming: 100 incrementing beats with bwd_valid_i=1 and fwd_ready_i=1 → each beat seen at output one cycle after acceptance, no gaps, count_o stays at 1.
- Ring wrap with DEPTH=3 (non-power-of-two): random valid/ready at 50% each for 1000 beats → output sequence equals input sequence; count_o never exceeds 3.
- Full boundary: at count_o=4, assert bwd_valid_i and pulse fwd_ready_i for one cycle → no push in that cycle; bwd_ready_o=1 in the next cycle; count_o=4 again after the next push.
- Flush (ELASTIC_BUF_FLUSH_EN defined):
  - With count_o=3, pulse flush_i while pushing 0x55 → next cycle count_o=0, fwd_valid_o=0.
  - A subsequent push of 0x66 appears at the output; 0x55 never appears.
